writeback_unit: RTL and testbench

//  Writeback stage feeding the register file write port (rd_en/rd/rd_din).

---
 rtl/writeback_unit.sv | 141 ++++++++++++++
 tb/tb_writeback_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and formatted load responses into one
// registered register-file write per cycle, tracking outstanding loads in order.
module writeback_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADR_W    = 5,
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADR_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADR_W-1:0]  ld_req_rd,
    input  logic [2:0]        ld_req_funct3,
    input  logic [1:0]        ld_req_offset,
    input  logic              ld_resp_valid,
    output logic              ld_resp_ready,
    input  logic [DATA_W-1:0] ld_resp_data,
    input  logic [ADR_W-1:0]  chk_rs,
    output logic              chk_hit,
    output logic              ld_busy,
    output logic              rd_en,
    output logic [ADR_W-1:0]  rd,
    output logic [DATA_W-1:0] rd_din
);

    localparam int unsigned PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);

    typedef struct packed {
        logic [ADR_W-1:0] rd;
        logic [2:0]       funct3;
        logic [1:0]       offset;
    } ld_entry_t;

    ld_entry_t            ld_q [LD_DEPTH];
    logic [LD_DEPTH-1:0]  ld_vld;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    ld_entry_t            head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 alu_fire;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [DATA_W-1:0]    ld_fmt;

    assign full          = (count == CNT_W'(LD_DEPTH));
    assign empty         = (count == '0);
    assign ld_req_ready  = !full;
    assign ld_resp_ready = !empty;
    assign ld_busy       = !empty;
    assign alu_ready     = !(ld_resp_valid && ld_resp_ready);

    assign push     = ld_req_valid && ld_req_ready;
    assign pop      = ld_resp_valid && ld_resp_ready;
    assign alu_fire = alu_valid && alu_ready;
    assign head     = ld_q[rd_ptr];

    // Load-use hazard check over every live entry, including one popping now
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < int'(LD_DEPTH); i++) begin
            if (ld_vld[i] && (ld_q[i].rd == chk_rs)) begin
                chk_hit = 1'b1;
            end
        end
        if (chk_rs == '0) begin
            chk_hit = 1'b0;
        end
    end

    // Extract and extend load data according to the head entry
    always_comb begin
        ld_byte = ld_resp_data[{head.offset, 3'b000} +: 8];
        ld_half = ld_resp_data[{head.offset[1], 4'b0000} +: 16];
        case (head.funct3)
            3'b000:  ld_fmt = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = DATA_W'(ld_byte);
            3'b101:  ld_fmt = DATA_W'(ld_half);
            default: ld_fmt = ld_resp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ld_q[wr_ptr] <= '{rd: ld_req_rd, funct3: ld_req_funct3, offset: ld_req_offset};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_vld <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ld_vld[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                ld_vld[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Write port register; loads win, x0 destinations never assert rd_en
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en  <= 1'b0;
            rd     <= '0;
            rd_din <= '0;
        end else if (pop) begin
            rd_en  <= (head.rd != '0);
            rd     <= head.rd;
            rd_din <= ld_fmt;
        end else if (alu_fire) begin
            rd_en  <= (alu_rd != '0);
            rd     <= alu_rd;
            rd_din <= alu_data;
        end else begin
            rd_en  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [4:0]  ld_req_rd;
    logic [2:0]  ld_req_funct3;
    logic [1:0]  ld_req_offset;
    logic        ld_resp_valid;
    logic        ld_resp_ready;
    logic [31:0] ld_resp_data;
    logic [4:0]  chk_rs;
    logic        chk_hit;
    logic        ld_busy;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] rd_din;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.DATA_W(32), .ADR_W(5), .LD_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_rd(ld_req_rd),
        .ld_req_funct3(ld_req_funct3), .ld_req_offset(ld_req_offset),
        .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready), .ld_resp_data(ld_resp_data),
        .chk_rs(chk_rs), .chk_hit(chk_hit), .ld_busy(ld_busy),
        .rd_en(rd_en), .rd(rd), .rd_din(rd_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_req_valid = 0; ld_req_rd = 0; ld_req_funct3 = 0; ld_req_offset = 0;
        ld_resp_valid = 0; ld_resp_data = 0; chk_rs = 0;
    endtask

    task automatic push_req(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off);
        ld_req_valid = 1; ld_req_rd = r; ld_req_funct3 = f3; ld_req_offset = off;
        tick();
        ld_req_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_rs = 5'd5;
        #1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", rd_en); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", rd); end
        checks++; if (rd_din !== 32'h0) begin errors++; $display("FAIL reset_rd_din got %h exp 0", rd_din); end
        checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL reset_ld_busy got %0b exp 0", ld_busy); end
        checks++; if (ld_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got %0b exp 0", ld_resp_ready); end
        checks++; if (ld_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", ld_req_ready); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL reset_chk_hit got %0b exp 0", chk_hit); end
        idle();
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL alu_rd_en got %0b exp 1", rd_en); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", rd); end
        checks++; if (rd_din !== 32'h1234) begin errors++; $display("FAIL alu_rd_din got %h exp 00001234", rd_din); end
        tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL alu_idle_rd_en got %0b exp 0", rd_en); end
        checks++; if (rd !== 5'd5 || rd_din !== 32'h1234) begin
            errors++; $display("FAIL alu_hold got rd=%0d din=%h exp rd=5 din=00001234", rd, rd_din);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b111, 3'b000, 3'b100};
        logic [1:0]  off [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1};
        logic [31:0] raw [8] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                                 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hAB00_0000, 32'h1234_5678};
        logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFAB, 32'h0000_0056};
        for (int i = 0; i < 8; i++) begin
            push_req(5'(i + 1), f3[i], off[i]);
            ld_resp_valid = 1; ld_resp_data = raw[i];
            #1;
            checks++; if (ld_resp_ready !== 1'b1) begin errors++; $display("FAIL fmt%0d_resp_ready got %0b exp 1", i, ld_resp_ready); end
            tick();
            ld_resp_valid = 0;
            checks++; if (rd_en !== 1'b1 || rd !== 5'(i + 1) || rd_din !== exp[i]) begin
                errors++;
                $display("FAIL fmt%0d got en=%0b rd=%0d din=%h exp en=1 rd=%0d din=%h", i, rd_en, rd, rd_din, i + 1, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_collision();
        push_req(5'd3, 3'b010, 2'd0);
        ld_resp_valid = 1; ld_resp_data = 32'h1111_1111;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h2222_2222;
        #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL coll_alu_ready got %0b exp 0", alu_ready); end
        tick();
        ld_resp_valid = 0;
        #1;
        checks++; if (rd_en !== 1'b1 || rd !== 5'd3 || rd_din !== 32'h1111_1111) begin
            errors++; $display("FAIL coll_load got en=%0b rd=%0d din=%h exp en=1 rd=3 din=11111111", rd_en, rd, rd_din);
        end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready2 got %0b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rd_en !== 1'b1 || rd !== 5'd4 || rd_din !== 32'h2222_2222) begin
            errors++; $display("FAIL coll_alu got en=%0b rd=%0d din=%h exp en=1 rd=4 din=22222222", rd_en, rd, rd_din);
        end
        tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL coll_dup got en=%0b exp 0", rd_en); end
    endtask

    task automatic test_queue_full();
        push_req(5'd8, 3'b010, 2'd0);
        push_req(5'd9, 3'b010, 2'd0);
        #1;
        checks++; if (ld_req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %0b exp 0", ld_req_ready); end
        checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b exp 1", ld_busy); end
        chk_rs = 5'd8; #1;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL full_hit8 got %0b exp 1", chk_hit); end
        chk_rs = 5'd9; #1;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL full_hit9 got %0b exp 1", chk_hit); end
        chk_rs = 5'd10; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL full_hit10 got %0b exp 0", chk_hit); end
        chk_rs = 5'd0; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL full_hit0 got %0b exp 0", chk_hit); end
        // request held while full: blocked this cycle, accepted alongside the next pop
        ld_req_valid = 1; ld_req_rd = 5'd10; ld_req_funct3 = 3'b010; ld_req_offset = 2'd0;
        ld_resp_valid = 1; ld_resp_data = 32'hA;
        tick();
        checks++; if (rd !== 5'd8 || rd_din !== 32'hA || rd_en !== 1'b1) begin
            errors++; $display("FAIL drain0 got en=%0b rd=%0d din=%h exp en=1 rd=8 din=0000000a", rd_en, rd, rd_din);
        end
        ld_resp_data = 32'hB;
        tick();
        ld_req_valid = 0;
        checks++; if (rd !== 5'd9 || rd_din !== 32'hB || rd_en !== 1'b1) begin
            errors++; $display("FAIL drain1 got en=%0b rd=%0d din=%h exp en=1 rd=9 din=0000000b", rd_en, rd, rd_din);
        end
        chk_rs = 5'd10; #1;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL pop_hit10 got %0b exp 1", chk_hit); end
        chk_rs = 5'd8; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL stale_hit8 got %0b exp 0", chk_hit); end
        ld_resp_data = 32'hC;
        tick();
        checks++; if (rd !== 5'd10 || rd_din !== 32'hC || rd_en !== 1'b1) begin
            errors++; $display("FAIL drain2 got en=%0b rd=%0d din=%h exp en=1 rd=10 din=0000000c", rd_en, rd, rd_din);
        end
        // response arriving with empty queue waits even though a push lands now
        ld_resp_data = 32'hD;
        ld_req_valid = 1; ld_req_rd = 5'd11; ld_req_funct3 = 3'b010; ld_req_offset = 2'd0;
        #1;
        checks++; if (ld_resp_ready !== 1'b0) begin errors++; $display("FAIL empty_resp_ready got %0b exp 0", ld_resp_ready); end
        tick();
        ld_req_valid = 0;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL empty_nowrite got en=%0b exp 0", rd_en); end
        tick();
        ld_resp_valid = 0;
        checks++; if (rd !== 5'd11 || rd_din !== 32'hD || rd_en !== 1'b1) begin
            errors++; $display("FAIL late_resp got en=%0b rd=%0d din=%h exp en=1 rd=11 din=0000000d", rd_en, rd, rd_din);
        end
        checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL drained_busy got %0b exp 0", ld_busy); end
        idle();
    endtask

    task automatic test_rd_zero();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready got %0b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL x0_alu_en got %0b exp 0", rd_en); end
        push_req(5'd0, 3'b010, 2'd0);
        chk_rs = 5'd0; #1;
        checks++; if (ld_busy !== 1'b1 || chk_hit !== 1'b0) begin
            errors++; $display("FAIL x0_queued got busy=%0b hit=%0b exp busy=1 hit=0", ld_busy, chk_hit);
        end
        ld_resp_valid = 1; ld_resp_data = 32'h77;
        #1;
        checks++; if (ld_resp_ready !== 1'b1) begin errors++; $display("FAIL x0_resp_ready got %0b exp 1", ld_resp_ready); end
        tick();
        ld_resp_valid = 0;
        checks++; if (rd_en !== 1'b0 || ld_busy !== 1'b0) begin
            errors++; $display("FAIL x0_load got en=%0b busy=%0b exp en=0 busy=0", rd_en, ld_busy);
        end
        idle();
    endtask

    task automatic test_reset_pending();
        push_req(5'd12, 3'b010, 2'd0);
        push_req(5'd13, 3'b010, 2'd0);
        rst = 1;
        ld_resp_valid = 1; ld_resp_data = 32'hEE;
        alu_valid = 1; alu_rd = 5'd14; alu_data = 32'hFF;
        tick();
        rst = 0;
        alu_valid = 0;
        chk_rs = 5'd12;
        #1;
        checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL rstp_busy got %0b exp 0", ld_busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rstp_rd_en got %0b exp 0", rd_en); end
        checks++; if (ld_req_ready !== 1'b1) begin errors++; $display("FAIL rstp_req_ready got %0b exp 1", ld_req_ready); end
        checks++; if (ld_resp_ready !== 1'b0) begin errors++; $display("FAIL rstp_resp_ready got %0b exp 0", ld_resp_ready); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL rstp_chk_hit got %0b exp 0", chk_hit); end
        tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rstp_stale got en=%0b exp 0", rd_en); end
        idle();
        tick();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alu();
        test_load_format();
        test_collision();
        test_queue_full();
        test_rd_zero();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
